// File: rtl/s15611_line_capture.sv
// Ping-pong line capture for the S15611 sensor: ADC samples framed by line_start are
// written into one of two line banks while the other bank streams out on AXI4-Stream.
module s15611_line_capture #(
    parameter int NUMBER_OF_PIXEL = 128,
    parameter int ADC_WIDTH       = 12,
    parameter int TDATA_WIDTH     = 16,
    parameter int COUNT_WIDTH     = 16
) (
    input  logic                   master_clock,
    input  logic                   reset,
    input  logic                   line_start,
    input  logic                   sample_capture_trigger,
    input  logic [ADC_WIDTH-1:0]   adc_data,
    output logic [TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic                   m_axis_tuser,
    output logic [COUNT_WIDTH-1:0] line_count,
    output logic [COUNT_WIDTH-1:0] dropped_count
);

    localparam int IDX_W = (NUMBER_OF_PIXEL > 1) ? $clog2(NUMBER_OF_PIXEL) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUMBER_OF_PIXEL - 1);

    typedef enum logic {W_IDLE, W_FILL} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_LOAD, R_STREAM} rd_state_t;

    wr_state_t wr_state, wr_next;
    rd_state_t rd_state, rd_next;

    logic [ADC_WIDTH-1:0] line_mem [2**(IDX_W+1)];
    logic [ADC_WIDTH-1:0] rd_data;
    logic [1:0]           bank_full;
    logic                 wr_bank, rd_bank;
    logic [IDX_W-1:0]     wr_idx, out_idx;

    logic start_ok, start_drop, fill_restart, wr_en, line_done;
    logic [IDX_W-1:0] wr_addr_idx, rd_addr_idx;
    logic handshake, beat_last, pkt_done, rd_en;

    // ---------------- write side ----------------
    always_ff @(posedge master_clock or posedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) wr_state <= W_IDLE;
        else       wr_state <= wr_next;
    end

    always_comb begin
        // NOTE: default assignment first keeps this combinational block from inferring a latch.
        wr_next = wr_state;
        case (wr_state)
            W_IDLE:  if (start_ok)  wr_next = W_FILL;
            W_FILL:  if (line_done) wr_next = W_IDLE;
            default: wr_next = W_IDLE;
        endcase
    end

    always_comb begin
        start_ok     = (wr_state == W_IDLE) && line_start && !bank_full[wr_bank];
        start_drop   = (wr_state == W_IDLE) && line_start &&  bank_full[wr_bank];
        fill_restart = (wr_state == W_FILL) && line_start;
        wr_en        = (wr_state == W_FILL) && sample_capture_trigger;
        // A restart with a coincident trigger lands that sample at index 0.
        wr_addr_idx  = fill_restart ? '0 : wr_idx;
        line_done    = wr_en && !line_start && (wr_idx == LAST_IDX);
    end

    always_ff @(posedge master_clock or posedge reset) begin
        if (reset) begin
            wr_idx  <= '0;
            wr_bank <= 1'b0;
        end else begin
            if (start_ok)
                wr_idx <= '0;
            else if (fill_restart)
                wr_idx <= sample_capture_trigger ? IDX_W'(1) : '0;
            else if (wr_en)
                wr_idx <= line_done ? '0 : wr_idx + IDX_W'(1);
            if (line_done)
                wr_bank <= ~wr_bank;
        end
    end

    // NOTE: the line RAM has no reset; bank_full gates every read, so stale contents are never seen.
    always_ff @(posedge master_clock) begin
        if (wr_en)
            line_mem[{wr_bank, wr_addr_idx}] <= adc_data;
    end

    // Full flags are set by the writer and cleared by the reader; they never hit the same bank at once.
    always_ff @(posedge master_clock or posedge reset) begin
        if (reset) begin
            bank_full <= 2'b00;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (line_done && (wr_bank == 1'(b)))
                    bank_full[b] <= 1'b1;
                else if (pkt_done && (rd_bank == 1'(b)))
                    bank_full[b] <= 1'b0;
            end
        end
    end

    // ---------------- read side ----------------
    always_ff @(posedge master_clock or posedge reset) begin
        if (reset) rd_state <= R_IDLE;
        else       rd_state <= rd_next;
    end

    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            R_IDLE:   if (bank_full[rd_bank]) rd_next = R_LOAD;
            R_LOAD:   rd_next = R_STREAM;
            R_STREAM: if (pkt_done) rd_next = R_IDLE;
            default:  rd_next = R_IDLE;
        endcase
    end

    always_comb begin
        m_axis_tvalid = (rd_state == R_STREAM);
        beat_last     = (out_idx == LAST_IDX);
        handshake     = m_axis_tvalid && m_axis_tready;
        pkt_done      = handshake && beat_last;
        // Fetch the next pixel during the handshake cycle so beats run back-to-back.
        rd_en         = (rd_state == R_LOAD) || (handshake && !beat_last);
        rd_addr_idx   = (rd_state == R_STREAM) ? out_idx + IDX_W'(1) : '0;
        m_axis_tlast  = m_axis_tvalid && beat_last;
        m_axis_tuser  = m_axis_tvalid && (out_idx == '0);
        m_axis_tdata  = TDATA_WIDTH'(rd_data);
    end

    always_ff @(posedge master_clock or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= line_mem[{rd_bank, rd_addr_idx}];
        end
    end

    always_ff @(posedge master_clock or posedge reset) begin
        if (reset) begin
            out_idx <= '0;
            rd_bank <= 1'b0;
        end else begin
            if (rd_state == R_LOAD)
                out_idx <= '0;
            else if (handshake && !beat_last)
                out_idx <= out_idx + IDX_W'(1);
            if (pkt_done)
                rd_bank <= ~rd_bank;
        end
    end

    // ---------------- statistics ----------------
    always_ff @(posedge master_clock or posedge reset) begin
        if (reset) begin
            line_count    <= '0;
            dropped_count <= '0;
        end else begin
            if (pkt_done)
                line_count <= line_count + COUNT_WIDTH'(1);
            if ((start_drop || fill_restart) && (dropped_count != '1))
                dropped_count <= dropped_count + COUNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_s15611_line_capture.sv
// Directed bench for s15611_line_capture: stimulus pushes expected beats into a queue,
// an independent monitor pops and compares every accepted beat and checks stall stability.
module tb_s15611_line_capture;

    localparam int N  = 128;
    localparam int AW = 12;
    localparam int DW = 16;
    localparam int CW = 16;

    logic          master_clock = 1'b0;
    logic          reset = 1'b1;
    logic          line_start = 1'b0;
    logic          sample_capture_trigger = 1'b0;
    logic [AW-1:0] adc_data = '0;
    logic          m_axis_tready = 1'b0;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid, m_axis_tlast, m_axis_tuser;
    logic [CW-1:0] line_count, dropped_count;

    s15611_line_capture #(
        .NUMBER_OF_PIXEL(N), .ADC_WIDTH(AW), .TDATA_WIDTH(DW), .COUNT_WIDTH(CW)
    ) dut (
        .master_clock(master_clock),
        .reset(reset),
        .line_start(line_start),
        .sample_capture_trigger(sample_capture_trigger),
        .adc_data(adc_data),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast),
        .m_axis_tuser(m_axis_tuser),
        .line_count(line_count),
        .dropped_count(dropped_count)
    );

    always #5 master_clock = ~master_clock;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic          user;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    passes = 0;
    int    beats_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    task automatic tick();
        @(posedge master_clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        line_start = 1'b0;
        sample_capture_trigger = 1'b0;
        m_axis_tready = 1'b0;
        repeat (3) tick();
        exp_q.delete();
        reset = 1'b0;
        tick();
    endtask

    // One line_start followed by n consecutive triggers carrying base+i; with_trig
    // puts the first sample in the line_start cycle itself.
    task automatic send_line(input int n, input int base, input bit push, input bit with_trig);
        beat_t b;
        if (push) begin
            for (int i = 0; i < n; i++) begin
                b.data = DW'(base + i);
                b.last = (i == N - 1);
                b.user = (i == 0);
                exp_q.push_back(b);
            end
        end
        line_start = 1'b1;
        sample_capture_trigger = with_trig;
        adc_data = AW'(base);
        tick();
        line_start = 1'b0;
        for (int i = (with_trig ? 1 : 0); i < n; i++) begin
            sample_capture_trigger = 1'b1;
            adc_data = AW'(base + i);
            tick();
        end
        sample_capture_trigger = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || m_axis_tvalid) && k < 2000) begin
            tick();
            k++;
        end
        check(name, exp_q.size(), 0);
    endtask

    // Monitor: samples on the falling edge, a beat is accepted at the following rising edge.
    initial begin
        logic  prev_stall;
        beat_t prev_beat, cur, want;
        prev_stall = 1'b0;
        prev_beat  = '0;
        forever begin
            @(negedge master_clock);
            cur = {m_axis_tdata, m_axis_tlast, m_axis_tuser};
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid", m_axis_tvalid, 1);
                    check("stall_hold", cur, prev_beat);
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_beat: got 0x%0h, required no beat", cur);
                    end else begin
                        want = exp_q.pop_front();
                        check("beat", cur, want);
                        beats_seen++;
                    end
                end
                prev_stall = m_axis_tvalid && !m_axis_tready;
                prev_beat  = cur;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        repeat (3) tick();
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tlast", m_axis_tlast, 0);
        check("rst_tuser", m_axis_tuser, 0);
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_line_count", line_count, 0);
        check("rst_dropped", dropped_count, 0);
        reset = 1'b0;
        tick();

        // 1: single line at full rate
        m_axis_tready = 1'b1;
        send_line(N, 0, 1, 0);
        wait_drain("t1_drain");
        check("t1_line_count", line_count, 1);
        check("t1_dropped", dropped_count, 0);

        // 2: downstream stalled for three lines, third has no free bank
        do_reset();
        m_axis_tready = 1'b0;
        send_line(N, 100, 1, 0);
        send_line(N, 200, 1, 0);
        send_line(N, 300, 0, 0);
        check("t2_dropped", dropped_count, 1);
        check("t2_line_count_stalled", line_count, 0);
        check("t2_tvalid_stalled", m_axis_tvalid, 1);
        m_axis_tready = 1'b1;
        wait_drain("t2_drain");
        check("t2_line_count", line_count, 2);
        repeat (5) tick();
        check("t2_idle", m_axis_tvalid, 0);

        // 3: short line restarted, then restart coinciding with a trigger
        do_reset();
        m_axis_tready = 1'b1;
        send_line(50, 1000, 0, 0);
        send_line(N, 200, 1, 0);
        wait_drain("t3_drain");
        check("t3_dropped", dropped_count, 1);
        check("t3_line_count", line_count, 1);
        send_line(30, 900, 0, 0);
        send_line(N, 400, 1, 1);
        wait_drain("t3b_drain");
        check("t3b_dropped", dropped_count, 2);
        check("t3b_line_count", line_count, 2);

        // 4: tready toggling every cycle
        do_reset();
        m_axis_tready = 1'b1;
        fork
            send_line(N, 300, 1, 0);
            begin
                for (int i = 0; i < 400; i++) begin
                    tick();
                    m_axis_tready = ~m_axis_tready;
                end
            end
        join
        m_axis_tready = 1'b1;
        wait_drain("t4_drain");
        check("t4_line_count", line_count, 1);

        // 5: reset at beat 60, counters carried over from the previous case
        beats_seen = 0;
        send_line(N, 500, 1, 0);
        k = 0;
        while (beats_seen < 60 && k < 1000) begin
            tick();
            k++;
        end
        check("t5_reach_beat60", beats_seen >= 60, 1);
        reset = 1'b1;
        #1;
        check("t5_tvalid_reset", m_axis_tvalid, 0);
        check("t5_tlast_reset", m_axis_tlast, 0);
        check("t5_line_count_reset", line_count, 0);
        check("t5_dropped_reset", dropped_count, 0);
        exp_q.delete();
        repeat (2) tick();
        reset = 1'b0;
        tick();
        check("t5_no_resume", m_axis_tvalid, 0);
        send_line(N, 700, 1, 0);
        wait_drain("t5_drain");
        check("t5_line_count", line_count, 1);
        check("t5_dropped", dropped_count, 0);

        // 6: line_start coincides with the tlast handshake while the other bank is full
        do_reset();
        m_axis_tready = 1'b0;
        send_line(N, 1100, 1, 0);
        send_line(N, 1300, 1, 0);
        m_axis_tready = 1'b1;
        k = 0;
        while (!(m_axis_tvalid && m_axis_tlast) && k < 1000) begin
            @(negedge master_clock);
            k++;
        end
        check("t6_reach_tlast", m_axis_tvalid && m_axis_tlast, 1);
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        check("t6_dropped", dropped_count, 1);
        for (int i = 0; i < 20; i++) begin
            sample_capture_trigger = 1'b1;
            adc_data = AW'(i);
            tick();
        end
        sample_capture_trigger = 1'b0;
        check("t6_dropped_hold", dropped_count, 1);
        send_line(N, 1500, 1, 0);
        wait_drain("t6_drain");
        check("t6_line_count", line_count, 3);
        check("t6_dropped_final", dropped_count, 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
